// File: rtl/sched_req_buffer_pkg.sv
// ---------------------------------------------------------------------------
// dram_pack
// Shared types and defaults for the DRAM command scheduler side.
//
// Contents:
//   SCHED_BUF_DEPTH_DEF  default number of queue entries in sched_req_buffer
//   SCHED_WORD_W_DEF     default address/data width of a scheduler request
//   sched_req_t          one queued request (write flag, address, store data)
//   sched_ptr_w()        pointer width helper for a power-of-two depth
// ---------------------------------------------------------------------------
package dram_pack;

    localparam int SCHED_BUF_DEPTH_DEF = 8;
    localparam int SCHED_WORD_W_DEF    = 32;

    typedef struct packed {
        logic                        wen;
        logic [SCHED_WORD_W_DEF-1:0] addr, data;
    } sched_req_t;

    // A depth of one would give a zero-width pointer, so clamp to one bit.
    function automatic int sched_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/scheduler_buffer_if.sv
// ---------------------------------------------------------------------------
// scheduler_buffer_if
// Bundles the requester <-> request buffer <-> scheduler signals.
//
// Parameters: WORD_W (address/data width), DEPTH (buffer entries).
// Modports:
//   requester  drives dREN/dWEN/ramaddr/memstore, sees dwait
//   scheduler  sees head/future entries and status, drives request_done
//   buffer     the sched_req_buffer side of everything above
// ---------------------------------------------------------------------------
interface scheduler_buffer_if
    import dram_pack::*;
#(
    parameter int WORD_W = SCHED_WORD_W_DEF,
    parameter int DEPTH  = SCHED_BUF_DEPTH_DEF
);

    logic                    dREN;
    logic                    dWEN;
    logic [WORD_W-1:0]       ramaddr;
    logic [WORD_W-1:0]       memstore;
    logic                    request_done;
    logic                    dwait;
    logic [WORD_W-1:0]       ramaddr_rq;
    logic [WORD_W-1:0]       ramstore_rq;
    logic                    ramREN_curr;
    logic                    ramWEN_curr;
    logic [WORD_W-1:0]       ramaddr_rq_ft;
    logic [WORD_W-1:0]       ramstore_rq_ft;
    logic                    ramREN_ftrt;
    logic                    ramWEN_ftrt;
    logic [WORD_W-1:0]       memaddr_callback;
    logic                    callback_valid;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    empty;

    modport requester (
        output dREN, dWEN, ramaddr, memstore,
        input  dwait
    );

    modport scheduler (
        input  ramaddr_rq, ramstore_rq, ramREN_curr, ramWEN_curr,
        input  ramaddr_rq_ft, ramstore_rq_ft, ramREN_ftrt, ramWEN_ftrt,
        input  memaddr_callback, callback_valid, count, full, empty,
        output request_done
    );

    modport buffer (
        input  dREN, dWEN, ramaddr, memstore, request_done,
        output dwait,
        output ramaddr_rq, ramstore_rq, ramREN_curr, ramWEN_curr,
        output ramaddr_rq_ft, ramstore_rq_ft, ramREN_ftrt, ramWEN_ftrt,
        output memaddr_callback, callback_valid, count, full, empty
    );

endinterface

// File: rtl/sched_req_buffer_fifo.sv
// ---------------------------------------------------------------------------
// sched_req_fifo
// In-order storage for sched_req_buffer: entry array, read/write pointers
// and occupancy count, with two read ports (head and head+1).
//
// Optional feature macro: SCHED_BUF_WCOALESCE_EN adds a tail read port and a
// tail data overwrite port used for write coalescing.
//
// Ports:
//   CLK, RST              clock, async active-high reset
//   push                  append {push_wen, push_addr, push_data}
//   pop                   drop the head entry (caller guarantees non-empty)
//   merge, merge_data     overwrite tail data (coalescing builds only)
//   tail_wen, tail_addr   tail entry fields (coalescing builds only)
//   head_*                entry at the read pointer
//   next_*                entry one behind the head
//   count                 occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sched_req_fifo
    import dram_pack::*;
#(
    parameter int WORD_W = SCHED_WORD_W_DEF,
    parameter int DEPTH  = SCHED_BUF_DEPTH_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   push_wen,
    input  logic [WORD_W-1:0]      push_addr,
    input  logic [WORD_W-1:0]      push_data,
`ifdef SCHED_BUF_WCOALESCE_EN
    input  logic                   merge,
    input  logic [WORD_W-1:0]      merge_data,
    output logic                   tail_wen,
    output logic [WORD_W-1:0]      tail_addr,
`endif
    output logic                   head_wen,
    output logic [WORD_W-1:0]      head_addr,
    output logic [WORD_W-1:0]      head_data,
    output logic                   next_wen,
    output logic [WORD_W-1:0]      next_addr,
    output logic [WORD_W-1:0]      next_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = sched_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              wen;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] nx_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign nx_ptr = rd_ptr + PW'(1);

    // Storage has no reset: stale slots are never presented because the
    // output decode masks everything beyond count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= '{wen: push_wen, addr: push_addr, data: push_data};
        end
`ifdef SCHED_BUF_WCOALESCE_EN
        if (merge) begin
            mem[wr_ptr - PW'(1)].data <= merge_data;
        end
`endif
    end

    // Pointer and occupancy update; simultaneous push and pop keep count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= nx_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_wen  = mem[rd_ptr].wen;
    assign head_addr = mem[rd_ptr].addr;
    assign head_data = mem[rd_ptr].data;
    assign next_wen  = mem[nx_ptr].wen;
    assign next_addr = mem[nx_ptr].addr;
    assign next_data = mem[nx_ptr].data;

`ifdef SCHED_BUF_WCOALESCE_EN
    assign tail_wen  = mem[wr_ptr - PW'(1)].wen;
    assign tail_addr = mem[wr_ptr - PW'(1)].addr;
`endif

endmodule

// File: rtl/sched_req_buffer.sv
// ---------------------------------------------------------------------------
// sched_req_buffer
// Request buffer between the tensor-core data-side requester and the DRAM
// command scheduler. Queues read/write requests in order, presents the head
// (current) and the entry behind it (future), retires the head on
// request_done and reports the retired address on a one-cycle callback.
//
// Optional feature macro: SCHED_BUF_WCOALESCE_EN -- a write to the same
// address as a queued tail write (tail not the head) overwrites the tail data
// instead of taking a new entry, and is accepted even when full.
//
// Ports:
//   CLK, RST                         clock, async active-high reset
//   dREN, dWEN, ramaddr, memstore    incoming request (write wins if both)
//   request_done                     scheduler finished the head entry
//   dwait                            request not accepted this cycle
//   ramaddr_rq, ramstore_rq,
//   ramREN_curr, ramWEN_curr         head entry
//   ramaddr_rq_ft, ramstore_rq_ft,
//   ramREN_ftrt, ramWEN_ftrt         second entry
//   memaddr_callback, callback_valid last retired address and its pulse
//   count, full, empty               occupancy status
// ---------------------------------------------------------------------------
module sched_req_buffer
    import dram_pack::*;
#(
    parameter int WORD_W = SCHED_WORD_W_DEF,
    parameter int DEPTH  = SCHED_BUF_DEPTH_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   dREN,
    input  logic                   dWEN,
    input  logic [WORD_W-1:0]      ramaddr,
    input  logic [WORD_W-1:0]      memstore,
    input  logic                   request_done,
    output logic                   dwait,
    output logic [WORD_W-1:0]      ramaddr_rq,
    output logic [WORD_W-1:0]      ramstore_rq,
    output logic                   ramREN_curr,
    output logic                   ramWEN_curr,
    output logic [WORD_W-1:0]      ramaddr_rq_ft,
    output logic [WORD_W-1:0]      ramstore_rq_ft,
    output logic                   ramREN_ftrt,
    output logic                   ramWEN_ftrt,
    output logic [WORD_W-1:0]      memaddr_callback,
    output logic                   callback_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic              req;
    logic              merge;
    logic              accept;
    logic              push;
    logic              pop;
    logic              head_wen;
    logic [WORD_W-1:0] head_addr;
    logic [WORD_W-1:0] head_data;
    logic              next_wen;
    logic [WORD_W-1:0] next_addr;
    logic [WORD_W-1:0] next_data;
    logic              curr_valid;
    logic              ftrt_valid;

`ifdef SCHED_BUF_WCOALESCE_EN
    logic              tail_wen;
    logic [WORD_W-1:0] tail_addr;
    logic              do_merge;
`endif

    assign req   = dREN | dWEN;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

`ifdef SCHED_BUF_WCOALESCE_EN
    // The head is excluded (count >= 2) because the scheduler may already
    // have issued it, so rewriting its data would be lost.
    assign merge = dWEN & tail_wen & (tail_addr == ramaddr) & (count >= CW'(2));
`else
    assign merge = 1'b0;
`endif

    // No bypass: a same-cycle pop never frees a slot for the incoming request.
    assign dwait  = req & full & ~merge;
    assign accept = req & ~dwait;
    assign push   = accept & ~merge;
    assign pop    = request_done & ~empty;

`ifdef SCHED_BUF_WCOALESCE_EN
    assign do_merge = accept & merge;
`endif

    sched_req_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push       (push),
        .pop        (pop),
        .push_wen   (dWEN),
        .push_addr  (ramaddr),
        .push_data  (memstore),
`ifdef SCHED_BUF_WCOALESCE_EN
        .merge      (do_merge),
        .merge_data (memstore),
        .tail_wen   (tail_wen),
        .tail_addr  (tail_addr),
`endif
        .head_wen   (head_wen),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .next_wen   (next_wen),
        .next_addr  (next_addr),
        .next_data  (next_data),
        .count      (count)
    );

    assign curr_valid = (count >= CW'(1));
    assign ftrt_valid = (count >= CW'(2));

    // Slots beyond count hold stale storage, so they are forced to zero.
    always_comb begin
        ramREN_curr    = 1'b0;
        ramWEN_curr    = 1'b0;
        ramaddr_rq     = '0;
        ramstore_rq    = '0;
        ramREN_ftrt    = 1'b0;
        ramWEN_ftrt    = 1'b0;
        ramaddr_rq_ft  = '0;
        ramstore_rq_ft = '0;
        if (curr_valid) begin
            ramREN_curr = ~head_wen;
            ramWEN_curr = head_wen;
            ramaddr_rq  = head_addr;
            ramstore_rq = head_data;
        end
        if (ftrt_valid) begin
            ramREN_ftrt    = ~next_wen;
            ramWEN_ftrt    = next_wen;
            ramaddr_rq_ft  = next_addr;
            ramstore_rq_ft = next_data;
        end
    end

    // The callback address holds its value between pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            callback_valid   <= 1'b0;
            memaddr_callback <= '0;
        end else begin
            callback_valid <= pop;
            if (pop) begin
                memaddr_callback <= head_addr;
            end
        end
    end

endmodule

// File: tb/tb_sched_req_buffer.sv
// ---------------------------------------------------------------------------
// tb_sched_req_buffer
// Directed bench for sched_req_buffer (WORD_W=32, DEPTH=8). Stimulus pushes
// the expected retire order into a queue; a monitor compares every callback
// pulse against it. Status outputs are checked directly after each step.
// ---------------------------------------------------------------------------
module tb_sched_req_buffer;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 8;

    logic              CLK;
    logic              RST;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] memstore;
    logic              request_done;
    logic              dwait;
    logic [WORD_W-1:0] ramaddr_rq;
    logic [WORD_W-1:0] ramstore_rq;
    logic              ramREN_curr;
    logic              ramWEN_curr;
    logic [WORD_W-1:0] ramaddr_rq_ft;
    logic [WORD_W-1:0] ramstore_rq_ft;
    logic              ramREN_ftrt;
    logic              ramWEN_ftrt;
    logic [WORD_W-1:0] memaddr_callback;
    logic              callback_valid;
    logic [3:0]        count;
    logic              full;
    logic              empty;

    int total;
    int bad;
    logic [31:0] exp_q[$];

    sched_req_buffer #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .dREN             (dREN),
        .dWEN             (dWEN),
        .ramaddr          (ramaddr),
        .memstore         (memstore),
        .request_done     (request_done),
        .dwait            (dwait),
        .ramaddr_rq       (ramaddr_rq),
        .ramstore_rq      (ramstore_rq),
        .ramREN_curr      (ramREN_curr),
        .ramWEN_curr      (ramWEN_curr),
        .ramaddr_rq_ft    (ramaddr_rq_ft),
        .ramstore_rq_ft   (ramstore_rq_ft),
        .ramREN_ftrt      (ramREN_ftrt),
        .ramWEN_ftrt      (ramWEN_ftrt),
        .memaddr_callback (memaddr_callback),
        .callback_valid   (callback_valid),
        .count            (count),
        .full             (full),
        .empty            (empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one request/done cycle, record the expected retire order, then
    // return 1 time unit after the clock edge with inputs idle again.
    task automatic applyStimulus(input logic ren, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic done, input bit exp_push);
        dREN         = ren;
        dWEN         = wen;
        ramaddr      = addr;
        memstore     = data;
        request_done = done;
        if (exp_push) exp_q.push_back(addr);
        @(posedge CLK);
        #1;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        ramaddr      = '0;
        memstore     = '0;
        request_done = 1'b0;
    endtask

    // Callback monitor: every pulse must match the oldest expected address.
    always @(negedge CLK) begin
        if (!RST && callback_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_callback", memaddr_callback, 32'hFFFF_FFFF);
            end else begin
                checkOutput("callback_addr", memaddr_callback, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total        = 0;
        bad          = 0;
        RST          = 1'b1;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        ramaddr      = '0;
        memstore     = '0;
        request_done = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset state
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_ren_curr", 32'(ramREN_curr), 32'd0);
        checkOutput("rst_wen_curr", 32'(ramWEN_curr), 32'd0);
        checkOutput("rst_cb_valid", 32'(callback_valid), 32'd0);
        checkOutput("rst_cb_addr", memaddr_callback, 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Single read
        applyStimulus(1, 0, 32'h100, 0, 0, 1);
        checkOutput("rd_ren_curr", 32'(ramREN_curr), 32'd1);
        checkOutput("rd_addr_curr", ramaddr_rq, 32'h100);
        checkOutput("rd_ren_ftrt", 32'(ramREN_ftrt), 32'd0);
        checkOutput("rd_addr_ftrt", ramaddr_rq_ft, 32'd0);
        checkOutput("rd_count", 32'(count), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("rd_pop_empty", 32'(empty), 32'd1);

        // Write then read; head/future, then retire head
        applyStimulus(0, 1, 32'h200, 32'hAA, 0, 1);
        applyStimulus(1, 0, 32'h300, 32'h0, 0, 1);
        checkOutput("wr_wen_curr", 32'(ramWEN_curr), 32'd1);
        checkOutput("wr_ren_curr", 32'(ramREN_curr), 32'd0);
        checkOutput("wr_addr_curr", ramaddr_rq, 32'h200);
        checkOutput("wr_data_curr", ramstore_rq, 32'hAA);
        checkOutput("wr_ren_ftrt", 32'(ramREN_ftrt), 32'd1);
        checkOutput("wr_addr_ftrt", ramaddr_rq_ft, 32'h300);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("wr_cb_valid", 32'(callback_valid), 32'd1);
        checkOutput("wr_cb_addr", memaddr_callback, 32'h200);
        checkOutput("wr_head_after", ramaddr_rq, 32'h300);
        checkOutput("wr_ftrt_after", 32'(ramREN_ftrt), 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wr_cb_drop", 32'(callback_valid), 32'd0);

        // Fill to DEPTH, 9th stalls, pop+push same cycle still stalls
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 0, 32'h1000 + 32'(i), 0, 0, 1);
        end
        checkOutput("fill_count", 32'(count), 32'd8);
        checkOutput("fill_full", 32'(full), 32'd1);
        dREN         = 1'b1;
        ramaddr      = 32'h1008;
        request_done = 1'b1;
        #1;
        checkOutput("fill_dwait_pop", 32'(dwait), 32'd1);
        @(posedge CLK);
        #1;
        request_done = 1'b0;
        checkOutput("fill_count_pop", 32'(count), 32'd7);
        checkOutput("fill_full_pop", 32'(full), 32'd0);
        checkOutput("fill_dwait_free", 32'(dwait), 32'd0);
        exp_q.push_back(32'h1008);
        @(posedge CLK);
        #1;
        dREN    = 1'b0;
        ramaddr = '0;
        checkOutput("fill_count_9th", 32'(count), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("fill_drained", 32'(empty), 32'd1);

        // Three fill/drain rounds, addresses 0..23, pointers wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                applyStimulus(1, 0, 32'(r * DEPTH + i), 0, 0, 1);
            end
            checkOutput("wrap_full", 32'(full), 32'd1);
            for (int i = 0; i < DEPTH; i++) begin
                applyStimulus(0, 0, 0, 0, 1, 0);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap_empty", 32'(empty), 32'd1);
        checkOutput("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        // request_done while empty is ignored
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("empty_done_cb", 32'(callback_valid), 32'd0);
        checkOutput("empty_done_count", 32'(count), 32'd0);

        // Reset with 5 entries queued
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 32'h500 + 32'(i), 32'h55, 0, 0);
        end
        checkOutput("pre_rst_count", 32'(count), 32'd5);
        RST = 1'b1;
        #1;
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_empty", 32'(empty), 32'd1);
        checkOutput("mid_rst_wen_curr", 32'(ramWEN_curr), 32'd0);
        checkOutput("mid_rst_addr_curr", ramaddr_rq, 32'd0);
        checkOutput("mid_rst_data_curr", ramstore_rq, 32'd0);
        checkOutput("mid_rst_wen_ftrt", 32'(ramWEN_ftrt), 32'd0);
        checkOutput("mid_rst_cb_addr", memaddr_callback, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Write coalescing
        applyStimulus(1, 0, 32'h10, 0, 0, 1);
        applyStimulus(0, 1, 32'h40, 32'd1, 0, 1);
`ifdef SCHED_BUF_WCOALESCE_EN
        applyStimulus(0, 1, 32'h40, 32'd2, 0, 0);
        checkOutput("coal_count", 32'(count), 32'd2);
        checkOutput("coal_ftrt_data", ramstore_rq_ft, 32'd2);
`else
        applyStimulus(0, 1, 32'h40, 32'd2, 0, 1);
        checkOutput("coal_count", 32'(count), 32'd3);
        checkOutput("coal_ftrt_data", ramstore_rq_ft, 32'd1);
`endif
        checkOutput("coal_ftrt_addr", ramaddr_rq_ft, 32'h40);
        checkOutput("coal_ftrt_wen", 32'(ramWEN_ftrt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("coal_empty", 32'(empty), 32'd1);
        checkOutput("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
